// File: rtl/frame_scheduler.sv
// Frame sequencer for the TX chain: muxes pilot then payload beats onto one
// valid/ready stream and generates first/last/pilot sidebands per beat.
module frame_scheduler #(
    parameter int LEN_WIDTH  = 13,
    parameter int DATA_WIDTH = 16,
    parameter int GAP_CYCLES = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_enable,
    input  logic [LEN_WIDTH-1:0]  cfg_frame_length,
    input  logic [LEN_WIDTH-1:0]  cfg_pilot_length,
    input  logic [DATA_WIDTH-1:0] pilot_tdata,
    input  logic                  pilot_tvalid,
    output logic                  pilot_tready,
    input  logic [DATA_WIDTH-1:0] payload_tdata,
    input  logic                  payload_tvalid,
    output logic                  payload_tready,
    output logic [DATA_WIDTH-1:0] m_tdata,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic                  m_tfirst,
    output logic                  m_tlast,
    output logic                  m_tpilot,
    output logic                  busy,
    output logic                  cfg_error,
    output logic [15:0]           frame_count
);

    typedef enum logic [1:0] {IDLE, PILOT, PAYLOAD, GAP} state_t;

    localparam int GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

    state_t               state, state_nxt;
    logic [LEN_WIDTH-1:0] beat, beat_nxt;
    logic [LEN_WIDTH-1:0] flen, flen_nxt;
    logic [LEN_WIDTH-1:0] plen, plen_nxt;
    logic [GW-1:0]        gap_cnt, gap_nxt;
    logic [15:0]          fcnt_nxt;
    logic                 err_nxt;
    logic                 cfg_valid;
    logic                 launch;
    logic                 fire;
    logic [LEN_WIDTH-1:0] flen_m1;
    logic [LEN_WIDTH-1:0] plen_m1;

    assign cfg_valid = (cfg_frame_length >= LEN_WIDTH'(2)) &&
                       (cfg_pilot_length < cfg_frame_length);
    assign flen_m1   = flen - LEN_WIDTH'(1);
    // Only used in PILOT, which is never entered with plen == 0.
    assign plen_m1   = plen - LEN_WIDTH'(1);
    assign fire      = m_tvalid & m_tready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            beat        <= '0;
            flen        <= '0;
            plen        <= '0;
            gap_cnt     <= '0;
            frame_count <= '0;
            cfg_error   <= 1'b0;
        end else begin
            state       <= state_nxt;
            beat        <= beat_nxt;
            flen        <= flen_nxt;
            plen        <= plen_nxt;
            gap_cnt     <= gap_nxt;
            frame_count <= fcnt_nxt;
            cfg_error   <= err_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        beat_nxt       = beat;
        flen_nxt       = flen;
        plen_nxt       = plen;
        gap_nxt        = gap_cnt;
        fcnt_nxt       = frame_count;
        err_nxt        = cfg_error;
        launch         = 1'b0;
        m_tdata        = '0;
        m_tvalid       = 1'b0;
        m_tfirst       = 1'b0;
        m_tlast        = 1'b0;
        m_tpilot       = 1'b0;
        pilot_tready   = 1'b0;
        payload_tready = 1'b0;
        busy           = 1'b0;

        case (state)
            IDLE: launch = 1'b1;
            PILOT: begin
                m_tdata      = pilot_tdata;
                m_tvalid     = pilot_tvalid;
                pilot_tready = m_tready;
                m_tpilot     = 1'b1;
                m_tfirst     = (beat == '0);
                busy         = 1'b1;
                if (fire) begin
                    beat_nxt = beat + LEN_WIDTH'(1);
                    if (beat == plen_m1)
                        state_nxt = PAYLOAD;
                end
            end
            PAYLOAD: begin
                m_tdata        = payload_tdata;
                m_tvalid       = payload_tvalid;
                payload_tready = m_tready;
                m_tfirst       = (beat == '0);
                m_tlast        = (beat == flen_m1);
                busy           = 1'b1;
                if (fire) begin
                    if (beat == flen_m1) begin
                        fcnt_nxt = frame_count + 16'd1;
                        if (GAP_CYCLES > 0) begin
                            state_nxt = GAP;
                            gap_nxt   = '0;
                        end else begin
                            launch = 1'b1;
                        end
                    end else begin
                        beat_nxt = beat + LEN_WIDTH'(1);
                    end
                end
            end
            GAP: begin
                if (gap_cnt == GW'(GAP_LAST))
                    launch = 1'b1;
                else
                    gap_nxt = gap_cnt + GW'(1);
            end
            default: state_nxt = IDLE;
        endcase

        // Common frame-start decision for IDLE, end of frame and end of gap.
        if (launch) begin
            state_nxt = IDLE;
            if (cfg_enable) begin
                if (cfg_valid) begin
                    flen_nxt  = cfg_frame_length;
                    plen_nxt  = cfg_pilot_length;
                    beat_nxt  = '0;
                    state_nxt = (cfg_pilot_length == '0) ? PAYLOAD : PILOT;
                end else begin
                    err_nxt = 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_frame_scheduler.sv
// Directed + randomized bench for frame_scheduler against a transaction-level
// model of the expected beat stream (frames of plen pilot then payload beats).
module tb_frame_scheduler;
    localparam int LW = 13;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_enable;
    logic [LW-1:0] cfg_frame_length, cfg_pilot_length;
    logic [DW-1:0] pilot_tdata, payload_tdata, m_tdata;
    logic          pilot_tvalid, pilot_tready, payload_tvalid, payload_tready;
    logic          m_tvalid, m_tready, m_tfirst, m_tlast, m_tpilot, busy, cfg_error;
    logic [15:0]   frame_count;

    always #5 clk = ~clk;

    frame_scheduler #(.LEN_WIDTH(LW), .DATA_WIDTH(DW), .GAP_CYCLES(0)) dut (
        .clk(clk), .rst(rst), .cfg_enable(cfg_enable),
        .cfg_frame_length(cfg_frame_length), .cfg_pilot_length(cfg_pilot_length),
        .pilot_tdata(pilot_tdata), .pilot_tvalid(pilot_tvalid), .pilot_tready(pilot_tready),
        .payload_tdata(payload_tdata), .payload_tvalid(payload_tvalid),
        .payload_tready(payload_tready),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
        .m_tfirst(m_tfirst), .m_tlast(m_tlast), .m_tpilot(m_tpilot),
        .busy(busy), .cfg_error(cfg_error), .frame_count(frame_count)
    );

    int checks = 0;
    int errors = 0;

    // stimulus knobs and source state
    int ready_mode, pv_pct, qv_pct, q_drop;
    bit tog;
    int p_idx, q_idx;

    // reference model: current frame, position in it, counters
    bit          in_frame, m_err;
    int          k, m_flen, m_plen, exp_p, exp_q, dut_beats;
    logic [15:0] m_count;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_cycle();
        bit ph_p, ph_q, ev, hs, start_ok, cfg_ok;
        case (ready_mode)
            0: m_tready = 1'b1;
            1: begin m_tready = tog; tog = ~tog; end
            default: m_tready = 1'($urandom_range(0, 1));
        endcase
        pilot_tvalid = ($urandom_range(0, 99) < pv_pct);
        if (q_drop > 0) begin payload_tvalid = 1'b0; q_drop--; end
        else payload_tvalid = ($urandom_range(0, 99) < qv_pct);
        pilot_tdata   = 16'(32'h1000 + p_idx);
        payload_tdata = 16'(32'h4000 + q_idx);
        @(negedge clk);
        ph_p = in_frame && (k < m_plen);
        ph_q = in_frame && !(k < m_plen);
        ev   = ph_p ? pilot_tvalid : (ph_q ? payload_tvalid : 1'b0);
        hs   = ev & m_tready;
        chk("busy", busy, in_frame);
        chk("m_tvalid", m_tvalid, ev);
        chk("m_tpilot", m_tpilot, ph_p);
        chk("pilot_tready", pilot_tready, ph_p & m_tready);
        chk("payload_tready", payload_tready, ph_q & m_tready);
        chk("m_tfirst", m_tfirst, in_frame && k == 0);
        chk("m_tlast", m_tlast, in_frame && k == m_flen - 1);
        chk("frame_count", frame_count, m_count);
        chk("cfg_error", cfg_error, m_err);
        if (hs) chk("m_tdata", m_tdata, ph_p ? 16'(32'h1000 + exp_p) : 16'(32'h4000 + exp_q));
        if (m_tvalid && m_tready) begin
            if (m_tfirst) dut_beats = 0;
            dut_beats++;
            if (m_tlast) chk("frame_len", dut_beats, m_flen);
        end
        if (pilot_tvalid && pilot_tready) p_idx++;
        if (payload_tvalid && payload_tready) q_idx++;
        cfg_ok = (cfg_frame_length >= 2) && (cfg_pilot_length < cfg_frame_length);
        if (!rst) begin
            in_frame = 0; k = 0; m_count = 0; m_err = 0; exp_p = p_idx; exp_q = q_idx;
        end else begin
            start_ok = !in_frame;
            if (in_frame && hs) begin
                if (ph_p) exp_p++; else exp_q++;
                if (k == m_flen - 1) begin m_count++; start_ok = 1; end
                else k++;
            end
            if (start_ok) begin
                in_frame = 0;
                if (cfg_enable) begin
                    if (cfg_ok) begin
                        in_frame = 1; k = 0;
                        m_flen = int'(cfg_frame_length); m_plen = int'(cfg_pilot_length);
                    end else m_err = 1;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_until_count(input logic [15:0] target, input int budget);
        int n = 0;
        while (m_count != target && n < budget) begin run_cycle(); n++; end
        chk("frame_timeout", 32'(n < budget), 1);
    endtask

    initial begin
        int n;
        bit dropped;
        rst = 0; cfg_enable = 0; cfg_frame_length = 8; cfg_pilot_length = 2;
        m_tready = 1; pilot_tvalid = 0; payload_tvalid = 0;
        pilot_tdata = '0; payload_tdata = '0;
        ready_mode = 0; pv_pct = 100; qv_pct = 100; q_drop = 0; tog = 1;
        p_idx = 0; q_idx = 0; in_frame = 0; m_err = 0; k = 0; m_flen = 0; m_plen = 0;
        exp_p = 0; exp_q = 0; dut_beats = 0; m_count = 0;
        repeat (2) @(posedge clk);
        #1;
        run_cycle();
        run_cycle();
        rst = 1;
        run_cycle();

        // basic frame 8/2
        cfg_enable = 1;
        run_cycle();
        cfg_enable = 0;
        run_until_count(1, 40);
        chk("basic_count", frame_count, 1);
        repeat (3) run_cycle();

        // backpressure with payload valid dropped for 3 cycles at beat 4
        ready_mode = 1; dropped = 0; n = 0;
        cfg_enable = 1;
        run_cycle();
        cfg_enable = 0;
        while (m_count != 2 && n < 80) begin
            if (in_frame && k == 4 && !dropped) begin q_drop = 3; dropped = 1; end
            run_cycle(); n++;
        end
        chk("bp_timeout", 32'(n < 80), 1);
        chk("bp_count", frame_count, 2);
        ready_mode = 0;
        repeat (2) run_cycle();

        // back-to-back, flen 8 -> 5 changed mid-frame: 1 latch cycle + 13 beats
        cfg_frame_length = 8; cfg_pilot_length = 2; cfg_enable = 1; n = 0;
        while (m_count != 4 && n < 60) begin
            if (in_frame && m_count == 2 && k == 3) cfg_frame_length = 5;
            if (m_count == 3) cfg_enable = 0;
            run_cycle(); n++;
        end
        chk("b2b_cycles", n, 14);
        cfg_enable = 0;
        repeat (2) run_cycle();

        // no pilot
        cfg_frame_length = 4; cfg_pilot_length = 0; cfg_enable = 1;
        run_cycle();
        cfg_enable = 0;
        run_until_count(5, 40);
        chk("nopilot_count", frame_count, 5);

        // invalid config, then corrected; error stays sticky
        cfg_frame_length = 3; cfg_pilot_length = 3; cfg_enable = 1;
        repeat (5) run_cycle();
        chk("inv_err", cfg_error, 1);
        chk("inv_valid", m_tvalid, 0);
        chk("inv_busy", busy, 0);
        cfg_pilot_length = 1;
        run_until_count(6, 40);
        cfg_enable = 0;
        run_until_count(7, 40);
        chk("inv_err_sticky", cfg_error, 1);
        repeat (2) run_cycle();

        // reset at beat 3 of 8
        cfg_frame_length = 8; cfg_pilot_length = 2; cfg_enable = 1;
        run_cycle();
        cfg_enable = 0; n = 0;
        while (!(in_frame && k == 3) && n < 40) begin run_cycle(); n++; end
        chk("rst_reach_beat3", 32'(n < 40), 1);
        rst = 0;
        run_cycle();
        rst = 1;
        chk("rst_count", frame_count, 0);
        chk("rst_valid", m_tvalid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", cfg_error, 0);
        cfg_enable = 1;
        run_cycle();
        cfg_enable = 0;
        run_until_count(1, 40);
        chk("rst_restart_count", frame_count, 1);

        // randomized traffic and configuration
        ready_mode = 2; pv_pct = 70; qv_pct = 70;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                cfg_frame_length = LW'($urandom_range(0, 10));
                cfg_pilot_length = LW'($urandom_range(0, 6));
                cfg_enable       = ($urandom_range(0, 3) != 0);
            end
            rst = ($urandom_range(0, 299) != 0);
            run_cycle();
        end
        rst = 1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
